// File: rtl/zvc_pkg.sv
// zvc_pkg: shared state encoding and count-width helper for the ZVC stream compressor
package zvc_pkg;
    typedef enum logic [1:0] {IDLE, COMPACT, OUTPUT} state_t;
    function automatic int cnt_width(input int line_size);
        return $clog2(line_size + 1);
    endfunction
endpackage

// File: rtl/zvc_lane_compactor.sv
// zvc_lane_compactor: packs the nonzero words of one chunk and their metadata toward slot 0
module zvc_lane_compactor #(
    parameter int WORD_WIDTH = 8,
    parameter int META_WIDTH = 28,
    parameter int LANES = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic [LANES*WORD_WIDTH-1:0] i_words,
    input  logic [LANES*META_WIDTH-1:0] i_meta,
    output logic [LANES*WORD_WIDTH-1:0] o_words,
    output logic [LANES*META_WIDTH-1:0] o_meta,
    output logic [LANES-1:0]            o_mask,
    output logic [CNT_WIDTH-1:0]        o_count
);
    for (genvar i = 0; i < LANES; i++) begin : g_mask
        assign o_mask[i] = |i_words[i*WORD_WIDTH +: WORD_WIDTH];
    end
    // p is the running prefix sum: the output slot of lane i is the number of nonzero lanes below it
    always_comb begin
        int p;
        p = 0;
        o_words = '0;
        o_meta = '0;
        for (int i = 0; i < LANES; i++) begin
            if (o_mask[i]) begin
                o_words[p*WORD_WIDTH +: WORD_WIDTH] = i_words[i*WORD_WIDTH +: WORD_WIDTH];
                o_meta[p*META_WIDTH +: META_WIDTH] = i_meta[i*META_WIDTH +: META_WIDTH];
            end
            p = p + int'(o_mask[i]);
        end
        o_count = CNT_WIDTH'(p);
    end
endmodule

// File: rtl/zvc_stream_compressor.sv
// zvc_stream_compressor: zero-value compression of one line per transaction, LANES words per cycle
module zvc_stream_compressor import zvc_pkg::*; #(
    parameter int WORD_WIDTH = 8,
    parameter int LINE_SIZE = 128,
    parameter int DIST_WIDTH = 7,
    parameter int MAX_LIFM_RSIZ = 4,
    parameter int LANES = 16,
    localparam int NCHUNK = LINE_SIZE / LANES,
    localparam int CNT_WIDTH = cnt_width(LINE_SIZE),
    localparam int MW = DIST_WIDTH * MAX_LIFM_RSIZ,
    localparam int LW = LINE_SIZE * WORD_WIDTH,
    localparam int MTW = LINE_SIZE * MW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 bypass,
    input  logic [LW-1:0]        lifm_line,
    input  logic [MTW-1:0]       mt_line,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LW-1:0]        lifm_comp,
    output logic [MTW-1:0]       mt_comp,
    output logic [LINE_SIZE-1:0] nz_mask,
    output logic [CNT_WIDTH-1:0] nz_count
);
    localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    state_t r_state, w_next;
    logic [KW-1:0] r_chunk;
    logic [CNT_WIDTH-1:0] r_wptr, w_wnext, w_ccount, w_line_cnt;
    logic [LW-1:0] r_lifm;
    logic [MTW-1:0] r_mt;
    logic r_bypass, w_accept, w_last;
    logic [LANES*WORD_WIDTH-1:0] w_cwords;
    logic [LANES*MW-1:0] w_cmeta;
    logic [LANES-1:0] w_cmask;
    logic [LINE_SIZE-1:0] w_line_mask;
    assign in_ready = r_state == IDLE;
    assign out_valid = r_state == OUTPUT;
    assign w_accept = in_valid && in_ready;
    assign w_last = r_chunk == KW'(NCHUNK - 1);
    assign w_wnext = r_wptr + w_ccount;
    for (genvar i = 0; i < LINE_SIZE; i++) begin : g_line_mask
        assign w_line_mask[i] = |lifm_line[i*WORD_WIDTH +: WORD_WIDTH];
    end
    always_comb begin
        w_line_cnt = '0;
        for (int i = 0; i < LINE_SIZE; i++) w_line_cnt = w_line_cnt + CNT_WIDTH'(w_line_mask[i]);
    end
    zvc_lane_compactor #(
        .WORD_WIDTH(WORD_WIDTH),
        .META_WIDTH(MW),
        .LANES(LANES),
        .CNT_WIDTH(CNT_WIDTH)
    ) u_lane (
        .i_words(r_lifm[r_chunk*LANES*WORD_WIDTH +: LANES*WORD_WIDTH]),
        .i_meta(r_mt[r_chunk*LANES*MW +: LANES*MW]),
        .o_words(w_cwords),
        .o_meta(w_cmeta),
        .o_mask(w_cmask),
        .o_count(w_ccount)
    );
    always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
    // bypass lines spend one cycle in COMPACT so out_valid rises one edge after accept
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? COMPACT : IDLE;
            COMPACT: w_next = (w_last || r_bypass) ? OUTPUT : COMPACT;
            OUTPUT:  w_next = out_ready ? IDLE : OUTPUT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_chunk <= '0;
            r_wptr <= '0;
            r_bypass <= 1'b0;
            r_lifm <= '0;
            r_mt <= '0;
            lifm_comp <= '0;
            mt_comp <= '0;
            nz_mask <= '0;
            nz_count <= '0;
        end else if (w_accept) begin
            r_chunk <= '0;
            r_wptr <= '0;
            r_bypass <= bypass;
            r_lifm <= lifm_line;
            r_mt <= mt_line;
            lifm_comp <= bypass ? lifm_line : '0;
            mt_comp <= bypass ? mt_line : '0;
            nz_mask <= bypass ? w_line_mask : '0;
            nz_count <= bypass ? w_line_cnt : '0;
        end else if (r_state == COMPACT && !r_bypass) begin
            r_chunk <= r_chunk + KW'(1);
            r_wptr <= w_wnext;
            lifm_comp <= lifm_comp | (LW'(w_cwords) << (r_wptr * WORD_WIDTH));
            mt_comp <= mt_comp | (MTW'(w_cmeta) << (r_wptr * MW));
            nz_mask[r_chunk*LANES +: LANES] <= w_cmask;
            nz_count <= w_wnext;
        end
    end
endmodule

// File: tb/tb_zvc_stream_compressor.sv
// tb_zvc_stream_compressor: table-driven directed lines plus random lines checked against a line-level model
module tb_zvc_stream_compressor;
    localparam int WW = 8, LS = 128, DW = 7, MR = 4, LN = 16;
    localparam int NCH = LS / LN, CW = $clog2(LS + 1), MW = DW * MR, LW = LS * WW, MTW = LS * MW;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, bypass, out_valid, out_ready;
    logic [LW-1:0] lifm_line, lifm_comp;
    logic [MTW-1:0] mt_line, mt_comp;
    logic [LS-1:0] nz_mask;
    logic [CW-1:0] nz_count;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    zvc_stream_compressor dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .bypass(bypass),
        .lifm_line(lifm_line), .mt_line(mt_line), .out_valid(out_valid), .out_ready(out_ready),
        .lifm_comp(lifm_comp), .mt_comp(mt_comp), .nz_mask(nz_mask), .nz_count(nz_count)
    );

    typedef struct {
        logic [LW-1:0]  lifm;
        logic [MTW-1:0] mt;
        logic           byp;
        logic [LW-1:0]  exp_lifm;
        logic [MTW-1:0] exp_mt;
        logic [LS-1:0]  exp_mask;
        int             exp_cnt;
        int             exp_lat;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [MTW-1:0] act, input logic [MTW-1:0] exp, input int w);
        logic [MTW-1:0] d, msk;
        int s;
        checks++;
        if (act !== exp) begin
            failures++;
            msk = MTW'((64'd1 << w) - 1);
            d = act ^ exp;
            s = 0;
            while (s < LS - 1 && ((d >> (s * w)) & msk) == 0) s++;
            $display("FAIL %s slot %0d: got %0h expected %0h", nm, s,
                     64'((act >> (s * w)) & msk), 64'((exp >> (s * w)) & msk));
        end
    endtask

    function automatic logic [LW-1:0] rand_line(input int pct);
        logic [LW-1:0] l = '0;
        for (int i = 0; i < LS; i++)
            if ($urandom_range(0, 99) < pct) l[i*WW +: WW] = WW'($urandom_range(1, 255));
        return l;
    endfunction

    function automatic logic [MTW-1:0] rand_meta();
        logic [MTW-1:0] m;
        for (int i = 0; i < LS; i++) m[i*MW +: MW] = MW'($urandom);
        return m;
    endfunction

    // reference: nonzero words and their metadata land in slot order, everything else zero
    task automatic model(input logic [LW-1:0] l, input logic [MTW-1:0] m, input logic b,
                         output logic [LW-1:0] el, output logic [MTW-1:0] em,
                         output logic [LS-1:0] ek, output int ec);
        int j;
        j = 0;
        el = '0;
        em = '0;
        ek = '0;
        for (int i = 0; i < LS; i++) begin
            ek[i] = l[i*WW +: WW] != 0;
            if (ek[i]) begin
                el[j*WW +: WW] = l[i*WW +: WW];
                em[j*MW +: MW] = m[i*MW +: MW];
                j++;
            end
        end
        ec = j;
        if (b) begin
            el = l;
            em = m;
        end
    endtask

    task automatic run_line(input string tag, input logic [LW-1:0] l, input logic [MTW-1:0] m, input logic b,
                            input logic [LW-1:0] el, input logic [MTW-1:0] em, input logic [LS-1:0] ek,
                            input int ec, input int elat, input int stall);
        int n, lat;
        logic busy_ok;
        logic [LW+MTW+LS+CW-1:0] snap;
        lifm_line = l;
        mt_line = m;
        bypass = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lifm_line = rand_line(50);
        mt_line = rand_meta();
        bypass = !b;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 4 * NCH) begin
            busy_ok &= !in_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " in_ready_busy"}, 64'(busy_ok), 64'd1);
        chk_vec({tag, " lifm_comp"}, MTW'(lifm_comp), MTW'(el), WW);
        chk_vec({tag, " mt_comp"}, mt_comp, em, MW);
        chk_vec({tag, " nz_mask"}, MTW'(nz_mask), MTW'(ek), 1);
        chk({tag, " nz_count"}, 64'(nz_count), 64'(ec));
        snap = {lifm_comp, mt_comp, nz_mask, nz_count};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall_stable"}, 64'(snap === {lifm_comp, mt_comp, nz_mask, nz_count}), 64'd1);
            chk({tag, " stall_valid_ready"}, {62'd0, out_valid, in_ready}, 64'b10);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " after_handshake"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [LW-1:0] el, l;
        logic [MTW-1:0] em, m;
        logic [LS-1:0] ek;
        int ec, pct;
        logic b;

        vecs[0].lifm = '0;
        vecs[0].lifm[3*WW +: WW] = 8'd13;
        vecs[0].lifm[8*WW +: WW] = 8'd47;
        vecs[0].lifm[15*WW +: WW] = 8'd22;
        for (int i = 0; i < LS; i++) vecs[0].mt[i*MW +: MW] = MW'(i + 100);
        vecs[0].byp = 1'b0;
        vecs[0].exp_lifm = '0;
        vecs[0].exp_lifm[0 +: 3*WW] = {8'd22, 8'd47, 8'd13};
        vecs[0].exp_mt = '0;
        vecs[0].exp_mt[0 +: 3*MW] = {MW'(115), MW'(108), MW'(103)};
        vecs[0].exp_mask = '0;
        vecs[0].exp_mask[3] = 1'b1;
        vecs[0].exp_mask[8] = 1'b1;
        vecs[0].exp_mask[15] = 1'b1;
        vecs[0].exp_cnt = 3;
        vecs[0].exp_lat = NCH;

        vecs[1].lifm = '0;
        vecs[1].mt = rand_meta();
        vecs[1].byp = 1'b0;
        vecs[1].exp_lifm = '0;
        vecs[1].exp_mt = '0;
        vecs[1].exp_mask = '0;
        vecs[1].exp_cnt = 0;
        vecs[1].exp_lat = NCH;

        vecs[2].lifm = {LS{8'hFF}};
        for (int i = 0; i < LS; i++) vecs[2].mt[i*MW +: MW] = MW'(i);
        vecs[2].byp = 1'b0;
        vecs[2].exp_lifm = vecs[2].lifm;
        vecs[2].exp_mt = vecs[2].mt;
        vecs[2].exp_mask = '1;
        vecs[2].exp_cnt = LS;
        vecs[2].exp_lat = NCH;

        vecs[3] = vecs[0];
        vecs[3].byp = 1'b1;
        vecs[3].exp_lifm = vecs[0].lifm;
        vecs[3].exp_mt = vecs[0].mt;
        vecs[3].exp_lat = 1;

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        bypass = 1'b0;
        lifm_line = '0;
        mt_line = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset valid_ready", {62'd0, out_valid, in_ready}, 64'b01);
        chk("reset nz_count", 64'(nz_count), 64'd0);
        chk_vec("reset lifm_comp", MTW'(lifm_comp), '0, WW);
        chk_vec("reset mt_comp", mt_comp, '0, MW);
        chk_vec("reset nz_mask", MTW'(nz_mask), '0, 1);

        for (int v = 0; v < 4; v++)
            run_line($sformatf("vec%0d", v), vecs[v].lifm, vecs[v].mt, vecs[v].byp, vecs[v].exp_lifm,
                     vecs[v].exp_mt, vecs[v].exp_mask, vecs[v].exp_cnt, vecs[v].exp_lat, 0);

        l = rand_line(30);
        m = rand_meta();
        model(l, m, 1'b0, el, em, ek, ec);
        run_line("stall5", l, m, 1'b0, el, em, ek, ec, NCH, 5);

        for (int r = 0; r < 40; r++) begin
            pct = $urandom_range(0, 10) * 10;
            b = $urandom_range(0, 3) == 0;
            l = rand_line(pct);
            m = rand_meta();
            model(l, m, b, el, em, ek, ec);
            run_line($sformatf("rand%0d", r), l, m, b, el, em, ek, ec, b ? 1 : NCH, $urandom_range(0, 3));
        end

        lifm_line = rand_line(60);
        mt_line = rand_meta();
        bypass = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort pre_reset busy", {62'd0, out_valid, in_ready}, 64'b00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort valid_ready", {62'd0, out_valid, in_ready}, 64'b01);
        chk("abort nz_count", 64'(nz_count), 64'd0);
        chk_vec("abort lifm_comp", MTW'(lifm_comp), '0, WW);
        chk_vec("abort nz_mask", MTW'(nz_mask), '0, 1);
        repeat (NCH + 2) @(posedge clk);
        #1;
        chk("abort no_partial", 64'(out_valid), 64'd0);
        l = rand_line(40);
        m = rand_meta();
        model(l, m, 1'b0, el, em, ek, ec);
        run_line("post_abort", l, m, 1'b0, el, em, ek, ec, NCH, 0);

        lifm_line = rand_line(50);
        in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reset = 1'b0;
        repeat (NCH + 3) @(posedge clk);
        #1;
        chk("reset_beats_accept", {62'd0, out_valid, in_ready}, 64'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
